// File: rtl/bank_port_arbiter.sv
// bank_port_arbiter: shares four memory banks among four requesters with a round-robin pointer per bank.
// Latency: req_ready is combinational in cycle t; bank_en/bank_we/sel_a/addr_q are registered and visible in t+1.
// Backpressure: a losing requester sees req_ready=0 and holds its request; every cycle is arbitrated afresh.
module bank_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req_valid,
  input  logic [1:0]        req_bank_0,
  input  logic [1:0]        req_bank_1,
  input  logic [1:0]        req_bank_2,
  input  logic [1:0]        req_bank_3,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [ADDR_W-1:0] req_addr_3,
  input  logic [3:0]        req_we,
  output logic [3:0]        req_ready,
  output logic [ADDR_W-1:0] addr_q_0,
  output logic [ADDR_W-1:0] addr_q_1,
  output logic [ADDR_W-1:0] addr_q_2,
  output logic [ADDR_W-1:0] addr_q_3,
  output logic [1:0]        sel_a_0,
  output logic [1:0]        sel_a_1,
  output logic [1:0]        sel_a_2,
  output logic [1:0]        sel_a_3,
  output logic [3:0]        bank_en,
  output logic [3:0]        bank_we,
  output logic [CNT_W-1:0]  conflict_cnt,
  input  logic              cnt_clr
);

  logic [1:0]        req_bank [4];
  logic [ADDR_W-1:0] req_addr [4];
  logic [1:0]        ptr      [4];
  logic [1:0]        win_idx  [4];
  logic [3:0]        win_vld;
  logic [3:0]        grant;
  logic [ADDR_W-1:0] addr_q   [4];
  logic [1:0]        sel_q    [4];
  logic [CNT_W-1:0]  cnt_q;
  logic              conflict;

  assign req_bank[0] = req_bank_0;
  assign req_bank[1] = req_bank_1;
  assign req_bank[2] = req_bank_2;
  assign req_bank[3] = req_bank_3;
  assign req_addr[0] = req_addr_0;
  assign req_addr[1] = req_addr_1;
  assign req_addr[2] = req_addr_2;
  assign req_addr[3] = req_addr_3;

  // Per bank: scan requesters starting at that bank's pointer; the first one targeting the bank wins
  always_comb begin
    win_vld = '0;
    grant   = '0;
    for (int k = 0; k < 4; k++) begin
      win_idx[k] = '0;
      for (int i = 0; i < 4; i++) begin
        if (!win_vld[k] && req_valid[ptr[k] + 2'(i)] && (req_bank[ptr[k] + 2'(i)] == 2'(k))) begin
          win_vld[k] = 1'b1;
          win_idx[k] = ptr[k] + 2'(i);
        end
      end
      if (win_vld[k]) begin
        grant[win_idx[k]] = 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is handed out that will be discarded
  assign req_ready = rst ? grant : 4'b0000;
  assign conflict  = |(req_valid & ~req_ready);

  // Register bank controls, crossbar selects, granted addresses and advance pointers past winners
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_en <= '0;
      bank_we <= '0;
      for (int k = 0; k < 4; k++) begin
        ptr[k]    <= '0;
        sel_q[k]  <= 2'(k);
        addr_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        bank_en[k] <= win_vld[k];
        bank_we[k] <= win_vld[k] & req_we[win_idx[k]];
        if (win_vld[k]) begin
          sel_q[k] <= win_idx[k];
          ptr[k]   <= win_idx[k] + 2'd1;
        end
      end
      for (int r = 0; r < 4; r++) begin
        if (grant[r]) begin
          addr_q[r] <= req_addr[r];
        end
      end
    end
  end

  // Saturating count of cycles where some valid requester was left waiting; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign addr_q_0     = addr_q[0];
  assign addr_q_1     = addr_q[1];
  assign addr_q_2     = addr_q[2];
  assign addr_q_3     = addr_q[3];
  assign sel_a_0      = sel_q[0];
  assign sel_a_1      = sel_q[1];
  assign sel_a_2      = sel_q[2];
  assign sel_a_3      = sel_q[3];
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bank_port_arbiter.sv
// tb_bank_port_arbiter: directed checks of bank_port_arbiter with a 4-bit conflict counter.
// Inputs are driven 1ns after the rising edge; outputs are compared 1-2ns after it.
// Each scenario task carries its own hand-computed expectations.
module tb_bank_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [1:0] req_bank_0, req_bank_1, req_bank_2, req_bank_3;
  logic [6:0] req_addr_0, req_addr_1, req_addr_2, req_addr_3;
  logic [3:0] req_we;
  logic [3:0] req_ready;
  logic [6:0] addr_q_0, addr_q_1, addr_q_2, addr_q_3;
  logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;
  logic [3:0] bank_en;
  logic [3:0] bank_we;
  logic [3:0] conflict_cnt;
  logic       cnt_clr;

  logic [6:0] aq [4];
  logic [1:0] sa [4];
  assign aq[0] = addr_q_0;
  assign aq[1] = addr_q_1;
  assign aq[2] = addr_q_2;
  assign aq[3] = addr_q_3;
  assign sa[0] = sel_a_0;
  assign sa[1] = sel_a_1;
  assign sa[2] = sel_a_2;
  assign sa[3] = sel_a_3;

  int tests = 0;
  int fails = 0;

  bank_port_arbiter #(.ADDR_W(7), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_bank_0(req_bank_0), .req_bank_1(req_bank_1), .req_bank_2(req_bank_2), .req_bank_3(req_bank_3),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1), .req_addr_2(req_addr_2), .req_addr_3(req_addr_3),
    .req_we(req_we), .req_ready(req_ready),
    .addr_q_0(addr_q_0), .addr_q_1(addr_q_1), .addr_q_2(addr_q_2), .addr_q_3(addr_q_3),
    .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3),
    .bank_en(bank_en), .bank_we(bank_we), .conflict_cnt(conflict_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    req_valid = 4'h0;
    cnt_clr = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cnt_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid = 4'($urandom); req_we = 4'($urandom);
      req_bank_0 = 2'($urandom); req_bank_1 = 2'($urandom);
      req_bank_2 = 2'($urandom); req_bank_3 = 2'($urandom);
      req_addr_0 = 7'($urandom); req_addr_1 = 7'($urandom);
      req_addr_2 = 7'($urandom); req_addr_3 = 7'($urandom);
      #1;
      tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL rst_ready got %h exp 0", req_ready); end
      step();
    end
    tests++; if (bank_en !== 4'h0) begin fails++; $display("FAIL rst_bank_en got %h exp 0", bank_en); end
    tests++; if (bank_we !== 4'h0) begin fails++; $display("FAIL rst_bank_we got %h exp 0", bank_we); end
    tests++; if (conflict_cnt !== 4'h0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", conflict_cnt); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (sa[k] !== 2'(k)) begin fails++; $display("FAIL rst_sel_a_%0d got %0d exp %0d", k, sa[k], k); end
      tests++; if (aq[k] !== 7'd0) begin fails++; $display("FAIL rst_addr_q_%0d got %0d exp 0", k, aq[k]); end
    end
  endtask

  task automatic test_all_distinct();
    rst = 1'b1;
    req_valid = 4'hF;
    req_bank_0 = 2'd2; req_bank_1 = 2'd0; req_bank_2 = 2'd3; req_bank_3 = 2'd1;
    req_addr_0 = 7'd10; req_addr_1 = 7'd20; req_addr_2 = 7'd30; req_addr_3 = 7'd40;
    req_we = 4'b0101;
    #1;
    tests++; if (req_ready !== 4'hF) begin fails++; $display("FAIL dist_ready got %h exp f", req_ready); end
    step();
    req_valid = 4'h0;
    tests++; if (bank_en !== 4'hF) begin fails++; $display("FAIL dist_bank_en got %h exp f", bank_en); end
    tests++; if (bank_we !== 4'b1100) begin fails++; $display("FAIL dist_bank_we got %b exp 1100", bank_we); end
    tests++; if ({sel_a_3, sel_a_2, sel_a_1, sel_a_0} !== {2'd2, 2'd0, 2'd3, 2'd1})
      begin fails++; $display("FAIL dist_sel got %0d,%0d,%0d,%0d exp 1,3,0,2", sel_a_0, sel_a_1, sel_a_2, sel_a_3); end
    tests++; if ({addr_q_0, addr_q_1, addr_q_2, addr_q_3} !== {7'd10, 7'd20, 7'd30, 7'd40})
      begin fails++; $display("FAIL dist_addr got %0d,%0d,%0d,%0d exp 10,20,30,40", addr_q_0, addr_q_1, addr_q_2, addr_q_3); end
    tests++; if (conflict_cnt !== 4'd0) begin fails++; $display("FAIL dist_cnt got %0d exp 0", conflict_cnt); end
  endtask

  task automatic test_same_bank();
    logic [3:0] we_pat;
    logic [6:0] exp_addr;
    do_reset();
    we_pat = 4'b1010;
    req_valid = 4'hF;
    req_bank_0 = 2'd2; req_bank_1 = 2'd2; req_bank_2 = 2'd2; req_bank_3 = 2'd2;
    req_addr_0 = 7'd50; req_addr_1 = 7'd51; req_addr_2 = 7'd52; req_addr_3 = 7'd53;
    req_we = we_pat;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (req_ready !== 4'(1 << i)) begin fails++; $display("FAIL same_ready_%0d got %b exp %b", i, req_ready, 4'(1 << i)); end
      step();
      exp_addr = 7'(50 + i);
      tests++; if (bank_en !== 4'b0100) begin fails++; $display("FAIL same_bank_en_%0d got %b exp 0100", i, bank_en); end
      tests++; if (sel_a_2 !== 2'(i)) begin fails++; $display("FAIL same_sel_%0d got %0d exp %0d", i, sel_a_2, i); end
      tests++; if (bank_we !== (we_pat[i] ? 4'b0100 : 4'b0000)) begin fails++; $display("FAIL same_we_%0d got %b", i, bank_we); end
      tests++; if (aq[i] !== exp_addr) begin fails++; $display("FAIL same_addr_%0d got %0d exp %0d", i, aq[i], exp_addr); end
      req_valid[i] = 1'b0;
    end
    tests++; if (conflict_cnt !== 4'd3) begin fails++; $display("FAIL same_cnt got %0d exp 3", conflict_cnt); end
    // pointer of bank 2 has wrapped to 0: r0 beats r1
    req_valid = 4'b0011;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL same_ptr_wrap got %b exp 0001", req_ready); end
    req_valid = 4'h0;
  endtask

  task automatic test_alternate();
    do_reset();
    req_valid = 4'b1001;
    req_bank_0 = 2'd1; req_bank_1 = 2'd0; req_bank_2 = 2'd0; req_bank_3 = 2'd1;
    req_we = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req_addr_0 = 7'(i * 3); req_addr_3 = 7'(100 + i);
      #1;
      tests++; if (req_ready !== ((i % 2 == 0) ? 4'b0001 : 4'b1000)) begin fails++; $display("FAIL alt_ready_%0d got %b", i, req_ready); end
      step();
      tests++; if (sel_a_1 !== ((i % 2 == 0) ? 2'd0 : 2'd3)) begin fails++; $display("FAIL alt_sel_%0d got %0d", i, sel_a_1); end
      tests++; if (bank_en !== 4'b0010) begin fails++; $display("FAIL alt_bank_en_%0d got %b exp 0010", i, bank_en); end
    end
    tests++; if (conflict_cnt !== 4'd4) begin fails++; $display("FAIL alt_cnt got %0d exp 4", conflict_cnt); end
  endtask

  task automatic test_saturate();
    repeat (20) step();
    tests++; if (conflict_cnt !== 4'd15) begin fails++; $display("FAIL sat_cnt got %0d exp 15", conflict_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    tests++; if (conflict_cnt !== 4'd0) begin fails++; $display("FAIL sat_clr got %0d exp 0", conflict_cnt); end
    step();
    tests++; if (conflict_cnt !== 4'd1) begin fails++; $display("FAIL sat_after_clr got %0d exp 1", conflict_cnt); end
    req_valid = 4'h0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0001;
    req_bank_0 = 2'd2; req_bank_1 = 2'd2;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first got %b exp 0001", req_ready); end
    step();
    rst = 1'b0;
    req_valid = 4'b0011;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready_in_rst got %b exp 0000", req_ready); end
    step();
    rst = 1'b1;
    #1;
    tests++; if (bank_en !== 4'b0000) begin fails++; $display("FAIL mid_bank_en got %b exp 0000", bank_en); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_ptr_restart got %b exp 0001", req_ready); end
    step();
    req_valid = 4'h0;
    tests++; if (sel_a_2 !== 2'd0 || bank_en !== 4'b0100) begin fails++; $display("FAIL mid_grant got sel %0d en %b exp sel 0 en 0100", sel_a_2, bank_en); end
  endtask

  task automatic test_drop();
    do_reset();
    req_valid = 4'b0011;
    req_bank_0 = 2'd0; req_bank_1 = 2'd0;
    req_addr_0 = 7'd5; req_addr_1 = 7'd6;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL drop_first got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    req_addr_1 = 7'd99;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL drop_ready got %b exp 0000", req_ready); end
    step();
    tests++; if (bank_en !== 4'b0000) begin fails++; $display("FAIL drop_bank_en got %b exp 0000", bank_en); end
    tests++; if (addr_q_1 !== 7'd0) begin fails++; $display("FAIL drop_addr_hold got %0d exp 0", addr_q_1); end
    tests++; if (addr_q_0 !== 7'd5 || sel_a_0 !== 2'd0) begin fails++; $display("FAIL drop_winner got addr %0d sel %0d exp 5 0", addr_q_0, sel_a_0); end
  endtask

  initial begin
    test_reset();
    test_all_distinct();
    test_same_bank();
    test_alternate();
    test_saturate();
    test_reset_mid();
    test_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
